// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit timing and data width.
// Used by uart_tx and its bit timer; the timing constant is shared with the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // 100 MHz system clock / 230400 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;
  localparam int BIT_IDX_W            = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake plus serial line of the UART transmitter.
// The producer of bytes uses the master modport; the transmitter uses the slave modport.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] din;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_serial;

  modport master (
    output tx_valid,
    output din,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  tx_serial
  );

  modport slave (
    input  tx_valid,
    input  din,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output tx_serial
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clr is high so the first bit after clr lasts a full period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (clr || (cnt_reg == LAST_CNT)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_end = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN inserts an even-parity bit.
// One byte per valid/ready handshake, serialised LSB first on a registered tx_serial.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next, shreg_shifted;
  logic [BIT_IDX_W-1:0] idx_reg, idx_next;
  logic                 serial_reg, serial_next;
  logic                 done_reg, done_next;
  logic                 bit_end;
  logic                 timer_clr;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  // Right shift toward bit 0; the vacated MSB fills with the idle level.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    if (gi == DATA_BITS - 1) begin : g_msb
      assign shreg_shifted[gi] = 1'b1;
    end else begin : g_mid
      assign shreg_shifted[gi] = shreg_reg[gi+1];
    end
  end

  assign timer_clr = (state_reg == IDLE);
  assign accept    = bus.tx_valid && (state_reg == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .bit_end(bit_end)
  );

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shreg_next = bus.din;
          idx_next   = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^bus.din;
`endif
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            shreg_next = shreg_shifted;
            idx_next   = idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the next state so tx_serial changes with the state flop.
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = parity_next;
`endif
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      idx_reg    <= '0;
      serial_reg <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      idx_reg    <= idx_next;
      serial_reg <= serial_next;
      done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign bus.tx_ready  = (state_reg == IDLE);
  assign bus.tx_busy   = (state_reg != IDLE);
  assign bus.tx_done   = done_reg;
  assign bus.tx_serial = serial_reg;

endmodule
